x_delay_os_mc: RTL and testbench

X_DELAY_OS_MC -- requirements
Module: x_delay_os_mc

---
 rtl/x_delay_pkg.sv | 10 +
 rtl/x_delay_os_ch.sv | 112 +++++++++++
 rtl/x_delay_os_mc.sv | 38 +++
 tb/tb_x_delay_os_mc.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/x_delay_pkg.sv
// Shared constants for the delayed one-shot channels: FSM state encodings.
package x_delay_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_PULSE = 2'd2
   } state_t;

endpackage

// File: rtl/x_delay_os_ch.sv
// One channel of the delayed one-shot: rising-edge trigger, delay/width
// down-counters, IDLE/DELAY/PULSE FSM, sticky drop flag. All outputs are
// registered from the current state, so q/busy appear one cycle after the
// state that produces them.
module x_delay_os_ch
   import x_delay_pkg::*;
#(
   parameter int MXDLY = 4,
   parameter int MXWID = 3
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             d_i,
   input  logic [MXDLY-1:0] delay_i,
   input  logic [MXWID-1:0] width_i,
   input  logic             rtrg_mode_i,
   input  logic             drop_clr_i,
   output logic             q_o,
   output logic             busy_o,
   output logic             drop_o
);

   state_t           state_q, state_d;
   logic             d_prev_q;
   logic [MXDLY-1:0] dcnt_q, dcnt_d;
   logic [MXWID-1:0] wcnt_q, wcnt_d;
   logic             q_q, q_d;
   logic             busy_q, busy_d;
   logic             evt_q, evt_d;
   logic             drop_q, drop_d;

   logic trig, pulse_last, idle_like, start, ignore;

   // A trigger landing on the final PULSE cycle behaves as if the channel were idle.
   always_comb begin
      trig       = d_i & ~d_prev_q;
      pulse_last = (state_q == ST_PULSE) && (wcnt_q == '0);
      idle_like  = (state_q == ST_IDLE) || pulse_last;
      start      = trig && (idle_like || rtrg_mode_i);
      ignore     = trig && !idle_like && !rtrg_mode_i;
   end

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic; a (re)start always takes priority over counting.
   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = (delay_i == '0) ? ST_PULSE : ST_DELAY;
      end else begin
         case (state_q)
            ST_IDLE:  state_d = ST_IDLE;
            ST_DELAY: if (dcnt_q == '0) state_d = ST_PULSE;
            ST_PULSE: if (wcnt_q == '0) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Counters load at the trigger (latching D and W) and count down to zero without wrapping;
   // wcnt holds the latched width during DELAY.
   always_comb begin
      dcnt_d = dcnt_q;
      wcnt_d = wcnt_q;
      if (start) begin
         dcnt_d = (delay_i == '0) ? '0 : delay_i - MXDLY'(1);
         wcnt_d = width_i;
      end else if ((state_q == ST_DELAY) && (dcnt_q != '0)) begin
         dcnt_d = dcnt_q - MXDLY'(1);
      end else if ((state_q == ST_PULSE) && (wcnt_q != '0)) begin
         wcnt_d = wcnt_q - MXWID'(1);
      end
   end

   // Output logic; an ignored trigger is staged one edge before it reaches the sticky flag.
   always_comb begin
      q_d    = (state_q == ST_PULSE);
      busy_d = (state_q != ST_IDLE);
      evt_d  = ignore;
      drop_d = evt_q | (drop_q & ~drop_clr_i);
   end

   // Datapath and output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         d_prev_q <= 1'b0;
         dcnt_q   <= '0;
         wcnt_q   <= '0;
         q_q      <= 1'b0;
         busy_q   <= 1'b0;
         evt_q    <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         d_prev_q <= d_i;
         dcnt_q   <= dcnt_d;
         wcnt_q   <= wcnt_d;
         q_q      <= q_d;
         busy_q   <= busy_d;
         evt_q    <= evt_d;
         drop_q   <= drop_d;
      end
   end

   assign q_o    = q_q;
   assign busy_o = busy_q;
   assign drop_o = drop_q;

endmodule

// File: rtl/x_delay_os_mc.sv
// Multi-channel delayed one-shot: slices the packed per-channel buses and
// instantiates one independent channel per lane.
module x_delay_os_mc #(
   parameter int NCH   = 4,
   parameter int MXDLY = 4,
   parameter int MXWID = 3
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [NCH-1:0]       d,
   input  logic [NCH*MXDLY-1:0] delay,
   input  logic [NCH*MXWID-1:0] width,
   input  logic [NCH-1:0]       rtrg_mode,
   input  logic                 drop_clr,
   output logic [NCH-1:0]       q,
   output logic [NCH-1:0]       busy,
   output logic [NCH-1:0]       drop
);

   for (genvar n = 0; n < NCH; n++) begin : g_ch
      x_delay_os_ch #(
         .MXDLY (MXDLY),
         .MXWID (MXWID)
      ) u_ch (
         .clock       (clock),
         .reset_n     (reset_n),
         .d_i         (d[n]),
         .delay_i     (delay[n*MXDLY +: MXDLY]),
         .width_i     (width[n*MXWID +: MXWID]),
         .rtrg_mode_i (rtrg_mode[n]),
         .drop_clr_i  (drop_clr),
         .q_o         (q[n]),
         .busy_o      (busy[n]),
         .drop_o      (drop[n])
      );
   end

endmodule

// File: tb/tb_x_delay_os_mc.sv
// Directed bench for x_delay_os_mc. Inputs change and outputs are sampled
// 1 time unit after each rising edge; "k" is the cycle index after the
// trigger edge T (k=0 is the cycle that follows edge T).
module tb_x_delay_os_mc;

   localparam int NCH   = 4;
   localparam int MXDLY = 4;
   localparam int MXWID = 3;

   logic                 clock;
   logic                 reset_n;
   logic [NCH-1:0]       d;
   logic [NCH*MXDLY-1:0] delay;
   logic [NCH*MXWID-1:0] width;
   logic [NCH-1:0]       rtrg_mode;
   logic                 drop_clr;
   logic [NCH-1:0]       q;
   logic [NCH-1:0]       busy;
   logic [NCH-1:0]       drop;

   int tests = 0;
   int fails = 0;

   x_delay_os_mc #(.NCH(NCH), .MXDLY(MXDLY), .MXWID(MXWID)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .d         (d),
      .delay     (delay),
      .width     (width),
      .rtrg_mode (rtrg_mode),
      .drop_clr  (drop_clr),
      .q         (q),
      .busy      (busy),
      .drop      (drop)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1);
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_dw(input int ch, input int dv, input int wv);
      logic [MXDLY-1:0] dl;
      logic [MXWID-1:0] wl;
      dl = dv[MXDLY-1:0];
      wl = wv[MXWID-1:0];
      delay[ch*MXDLY +: MXDLY] = dl;
      width[ch*MXWID +: MXWID] = wl;
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chkv(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   int dn [NCH] = '{1, 2, 0, 3};
   int wn [NCH] = '{0, 1, 3, 2};

   initial begin
      reset_n   = 1'b0;
      d         = '0;
      delay     = '0;
      width     = '0;
      rtrg_mode = '0;
      drop_clr  = 1'b0;

      // reset state
      repeat (3) step();
      chkv("rst q", q, 4'b0000);
      chkv("rst busy", busy, 4'b0000);
      chkv("rst drop", drop, 4'b0000);

      // d high at the first edge after release is a trigger (ch3, D=0 W=0)
      set_dw(3, 0, 0);
      d[3] = 1'b1;
      reset_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         chkb($sformatf("post-rst q3 k=%0d", k), q[3], k == 1);
         chkb($sformatf("post-rst busy3 k=%0d", k), busy[3], k == 1);
      end
      d[3] = 1'b0;
      step();

      // D=3 W=0 single rise on ch0: q only at k=4, busy k=1..4
      set_dw(0, 3, 0);
      d[0] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         if (k == 1) d[0] = 1'b0;
         chkb($sformatf("d3w0 q0 k=%0d", k), q[0], k == 4);
         chkb($sformatf("d3w0 busy0 k=%0d", k), busy[0], (k >= 1) && (k <= 4));
      end

      // D=0 W=2 with d held high 20 cycles on ch1: one pulse k=1..3
      set_dw(1, 0, 2);
      d[1] = 1'b1;
      for (int k = 0; k < 22; k++) begin
         step();
         if (k == 19) d[1] = 1'b0;
         chkb($sformatf("held q1 k=%0d", k), q[1], (k >= 1) && (k <= 3));
         chkb($sformatf("held busy1 k=%0d", k), busy[1], (k >= 1) && (k <= 3));
      end

      // rtrg_mode=0, D=5 on ch2, second rise at T+2: pulse at k=6, drop from k=3
      set_dw(2, 5, 0);
      rtrg_mode[2] = 1'b0;
      d[2] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         chkb($sformatf("ign q2 k=%0d", k), q[2], k == 6);
         chkb($sformatf("ign drop2 k=%0d", k), drop[2], k >= 3);
         if (k == 0) d[2] = 1'b0;
         else if (k == 1) d[2] = 1'b1;
         else if (k == 2) d[2] = 1'b0;
      end
      drop_clr = 1'b1;
      step();
      drop_clr = 1'b0;
      chkv("drop_clr drop", drop, 4'b0000);

      // rtrg_mode=1, D=5 on ch2, second rise at R=T+2: pulse only at k=8, no drop
      rtrg_mode[2] = 1'b1;
      d[2] = 1'b1;
      for (int k = 0; k < 11; k++) begin
         step();
         chkb($sformatf("rtrg q2 k=%0d", k), q[2], k == 8);
         chkb($sformatf("rtrg drop2 k=%0d", k), drop[2], 1'b0);
         if (k == 0) d[2] = 1'b0;
         else if (k == 1) d[2] = 1'b1;
         else if (k == 2) d[2] = 1'b0;
      end
      rtrg_mode[2] = 1'b0;

      // trigger on the PULSE->IDLE edge (ch1, D=0 W=1): abutting pulses k=1..4, no drop
      set_dw(1, 0, 1);
      d[1] = 1'b1;
      for (int k = 0; k < 7; k++) begin
         step();
         chkb($sformatf("abut q1 k=%0d", k), q[1], (k >= 1) && (k <= 4));
         chkb($sformatf("abut drop1 k=%0d", k), drop[1], 1'b0);
         if (k == 0) d[1] = 1'b0;
         else if (k == 1) d[1] = 1'b1;
         else if (k == 2) d[1] = 1'b0;
      end

      // all-ones D=15 W=7 on ch0: q k=16..23, busy k=1..23
      set_dw(0, 15, 7);
      d[0] = 1'b1;
      for (int k = 0; k < 26; k++) begin
         step();
         if (k == 0) d[0] = 1'b0;
         chkb($sformatf("max q0 k=%0d", k), q[0], (k >= 16) && (k <= 23));
         chkb($sformatf("max busy0 k=%0d", k), busy[0], (k >= 1) && (k <= 23));
      end

      // four channels, distinct D/W, simultaneous rise
      for (int n = 0; n < NCH; n++) set_dw(n, dn[n], wn[n]);
      d = 4'b1111;
      for (int k = 0; k < 9; k++) begin
         step();
         if (k == 0) d = 4'b0000;
         for (int n = 0; n < NCH; n++)
            chkb($sformatf("multi q%0d k=%0d", n, k), q[n],
                 (k >= dn[n] + 1) && (k <= dn[n] + wn[n] + 1));
      end
      chkv("multi drop", drop, 4'b0000);

      // reset at T+2 with D=4 on ch0 aborts the pending pulse
      set_dw(0, 4, 1);
      d[0] = 1'b1;
      step();
      d[0] = 1'b0;
      step();
      step();
      chkb("pre-abort busy0", busy[0], 1'b1);
      reset_n = 1'b0;
      #1;
      chkv("abort q", q, 4'b0000);
      chkv("abort busy", busy, 4'b0000);
      chkv("abort drop", drop, 4'b0000);
      step();
      reset_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         chkb($sformatf("after-abort q0 k=%0d", k), q[0], 1'b0);
         chkb($sformatf("after-abort busy0 k=%0d", k), busy[0], 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
